// File: rtl/memory_stage.sv
// Memory pipeline stage: EX/MEM register, word-wide data-memory req/ack access with timeout and
// misalignment abort, MEM/WB register and M-stage forwarding outputs.
module memory_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_valid,
  input  logic [DATA_WIDTH-1:0]     execute_out_e,
  input  logic [DATA_WIDTH-1:0]     reg_readdata2_e_out,
  input  logic [REG_ADDR_WIDTH-1:0] reg_write_addr_e,
  input  logic                      reg_write_en_e,
  input  logic                      dmem_read_en_e,
  input  logic                      dmem_write_en_e,
  input  logic                      reg_writedata_sel_e,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [DATA_WIDTH-1:0]     dmem_addr,
  output logic [DATA_WIDTH-1:0]     dmem_wdata,
  input  logic                      dmem_ack,
  input  logic [DATA_WIDTH-1:0]     dmem_rdata,
  output logic                      mem_stall,
  output logic                      mem_err,
  output logic [REG_ADDR_WIDTH-1:0] m_reg_write_addr,
  output logic                      m_reg_write_en,
  output logic [DATA_WIDTH-1:0]     m_execute_out,
  output logic                      wb_valid,
  output logic [REG_ADDR_WIDTH-1:0] wb_reg_write_addr,
  output logic                      wb_reg_write_en,
  output logic [DATA_WIDTH-1:0]     wb_writedata
);

  typedef enum logic {IDLE, WAIT} state_t;

  // cnt holds the number of request cycles already spent without ack
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic TIMEOUT_ON = (TIMEOUT_CYCLES != 0);

  logic                      valid_m;
  logic [DATA_WIDTH-1:0]     addr_m;
  logic [DATA_WIDTH-1:0]     wdata_m;
  logic [REG_ADDR_WIDTH-1:0] rd_m;
  logic                      we_m;
  logic                      read_m;
  logic                      write_m;
  logic                      sel_m;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] elapsed;
  logic          mem_op, misaligned, timeout, abort;

  assign mem_op     = valid_m & (read_m | write_m);
  assign misaligned = mem_op & (addr_m[1:0] != 2'b00);
  // rst_n gating drops the request the instant reset asserts
  assign dmem_req   = mem_op & ~misaligned & rst_n;
  assign dmem_we    = write_m;
  assign dmem_addr  = addr_m;
  assign dmem_wdata = wdata_m;

  assign elapsed   = (state == WAIT) ? cnt : '0;
  assign timeout   = TIMEOUT_ON & dmem_req & ~dmem_ack & (elapsed == CNT_LAST);
  assign mem_stall = dmem_req & ~dmem_ack & ~timeout;
  assign abort     = misaligned | timeout;
  assign mem_err   = abort;

  assign m_reg_write_addr = rd_m;
  assign m_reg_write_en   = valid_m & we_m & ~read_m;
  assign m_execute_out    = addr_m;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (mem_stall) begin
        state_nxt = WAIT;
        cnt_nxt   = CW'(1);
      end
      WAIT: if (!mem_stall) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_m <= 1'b0;
      addr_m  <= '0;
      wdata_m <= '0;
      rd_m    <= '0;
      we_m    <= 1'b0;
      read_m  <= 1'b0;
      write_m <= 1'b0;
      sel_m   <= 1'b0;
    end else if (!mem_stall) begin
      valid_m <= ex_valid;
      addr_m  <= execute_out_e;
      wdata_m <= reg_readdata2_e_out;
      rd_m    <= reg_write_addr_e;
      we_m    <= reg_write_en_e;
      read_m  <= dmem_read_en_e;
      write_m <= dmem_write_en_e;
      sel_m   <= reg_writedata_sel_e;
    end
  end

  // a stall cycle pushes a bubble into writeback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid          <= 1'b0;
      wb_reg_write_addr <= '0;
      wb_reg_write_en   <= 1'b0;
      wb_writedata      <= '0;
    end else if (!mem_stall) begin
      wb_valid          <= valid_m;
      wb_reg_write_addr <= rd_m;
      wb_reg_write_en   <= valid_m & we_m & ~abort;
      wb_writedata      <= sel_m ? dmem_rdata : addr_m;
    end else begin
      wb_valid        <= 1'b0;
      wb_reg_write_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed vector table, multi-cycle corner sequences and a
// randomized run against an instruction-level reference model.
module tb_memory_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] execute_out_e, reg_readdata2_e_out, dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] m_execute_out, wb_writedata;
  logic [4:0]  reg_write_addr_e, m_reg_write_addr, wb_reg_write_addr;
  logic        reg_write_en_e, dmem_read_en_e, dmem_write_en_e, reg_writedata_sel_e;
  logic        dmem_req, dmem_we, dmem_ack, mem_stall, mem_err, m_reg_write_en;
  logic        wb_valid, wb_reg_write_en;

  memory_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .execute_out_e(execute_out_e),
    .reg_readdata2_e_out(reg_readdata2_e_out), .reg_write_addr_e(reg_write_addr_e),
    .reg_write_en_e(reg_write_en_e), .dmem_read_en_e(dmem_read_en_e),
    .dmem_write_en_e(dmem_write_en_e), .reg_writedata_sel_e(reg_writedata_sel_e),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .mem_stall(mem_stall), .mem_err(mem_err),
    .m_reg_write_addr(m_reg_write_addr), .m_reg_write_en(m_reg_write_en),
    .m_execute_out(m_execute_out), .wb_valid(wb_valid), .wb_reg_write_addr(wb_reg_write_addr),
    .wb_reg_write_en(wb_reg_write_en), .wb_writedata(wb_writedata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic v; logic [31:0] a; logic [31:0] d; logic [4:0] rd;
    logic we; logic re; logic wr; logic sel;
  } ins_t;

  typedef struct packed {
    ins_t i; logic ack; logic [31:0] rdata;
    logic x_req; logic x_stall; logic x_err; logic x_wbv; logic x_wbwe; logic [31:0] x_wbd;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic ins_t mk(input logic v, input logic [31:0] a, input logic [31:0] d,
                              input logic [4:0] rd, input logic we, input logic re,
                              input logic wr, input logic sel);
    ins_t r;
    r.v = v; r.a = a; r.d = d; r.rd = rd; r.we = we; r.re = re; r.wr = wr; r.sel = sel;
    return r;
  endfunction

  function automatic vec_t mv(input ins_t i, input logic ack, input logic [31:0] rdata,
                              input logic xr, input logic xs, input logic xe,
                              input logic xv, input logic xw, input logic [31:0] xd);
    vec_t r;
    r.i = i; r.ack = ack; r.rdata = rdata; r.x_req = xr; r.x_stall = xs; r.x_err = xe;
    r.x_wbv = xv; r.x_wbwe = xw; r.x_wbd = xd;
    return r;
  endfunction

  task automatic drive(input ins_t i);
    ex_valid = i.v; execute_out_e = i.a; reg_readdata2_e_out = i.d; reg_write_addr_e = i.rd;
    reg_write_en_e = i.we; dmem_read_en_e = i.re; dmem_write_en_e = i.wr;
    reg_writedata_sel_e = i.sel;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  ins_t bubble, cur, mref;
  vec_t tbl[8];
  int   waited;
  logic exp_req, exp_mis, exp_to, exp_stall, ewv, ewwe, prev_stall;
  logic [4:0]  ewrd;
  logic [31:0] ewd;

  initial begin
    bubble = '0;
    tbl[0] = mv(mk(1, 32'h0000_1234, 0, 5'd5, 1, 0, 0, 0), 0, 0, 0, 0, 0, 1, 1, 32'h0000_1234);
    tbl[1] = mv(mk(1, 32'h0000_0100, 0, 5'd7, 1, 1, 0, 1), 1, 32'hDEAD_BEEF, 1, 0, 0, 1, 1, 32'hDEAD_BEEF);
    tbl[2] = mv(mk(1, 32'h0000_0200, 32'hCAFE_F00D, 5'd0, 0, 0, 1, 0), 1, 0, 1, 0, 0, 1, 0, 32'h0000_0200);
    tbl[3] = mv(mk(1, 32'h0000_0102, 0, 5'd3, 1, 1, 0, 1), 0, 32'h55, 0, 0, 1, 1, 0, 32'h55);
    tbl[4] = mv(mk(0, 32'h0000_0101, 0, 5'd4, 1, 1, 0, 0), 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[5] = mv(mk(1, 32'h0000_0203, 32'h1111_2222, 5'd0, 0, 0, 1, 0), 0, 0, 0, 0, 1, 1, 0, 32'h0000_0203);
    tbl[6] = mv(mk(1, 32'hFFFF_0000, 0, 5'd31, 0, 0, 0, 0), 0, 0, 0, 0, 0, 1, 0, 32'hFFFF_0000);
    tbl[7] = mv(mk(1, 32'h0000_0ABC, 32'h7, 5'd12, 1, 1, 0, 1), 1, 32'h0123_4567, 1, 0, 0, 1, 1, 32'h0123_4567);

    rst_n = 1'b0; drive(bubble); dmem_ack = 0; dmem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", dmem_req, 0);  chk("rst_stall", mem_stall, 0); chk("rst_err", mem_err, 0);
    chk("rst_wbv", wb_valid, 0);  chk("rst_wbwe", wb_reg_write_en, 0);
    chk("rst_wbd", wb_writedata, 0); chk("rst_maddr", dmem_addr, 0); chk("rst_mfwd", m_reg_write_en, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // directed table: instruction in cycle A, memory response in cycle B
    for (int k = 0; k < 8; k++) begin
      drive(tbl[k].i); dmem_ack = 0;
      tick();
      drive(bubble); dmem_ack = tbl[k].ack; dmem_rdata = tbl[k].rdata;
      #1;
      chk($sformatf("v%0d_req", k), dmem_req, tbl[k].x_req);
      chk($sformatf("v%0d_stall", k), mem_stall, tbl[k].x_stall);
      chk($sformatf("v%0d_err", k), mem_err, tbl[k].x_err);
      chk($sformatf("v%0d_fwd_en", k), m_reg_write_en, tbl[k].i.v & tbl[k].i.we & ~tbl[k].i.re);
      chk($sformatf("v%0d_fwd_d", k), m_execute_out, tbl[k].i.a);
      chk($sformatf("v%0d_fwd_a", k), m_reg_write_addr, tbl[k].i.rd);
      if (tbl[k].x_req) begin
        chk($sformatf("v%0d_addr", k), dmem_addr, tbl[k].i.a);
        chk($sformatf("v%0d_we", k), dmem_we, tbl[k].i.wr);
        if (tbl[k].i.wr) chk($sformatf("v%0d_wdata", k), dmem_wdata, tbl[k].i.d);
      end
      tick(); dmem_ack = 0;
      chk($sformatf("v%0d_wbv", k), wb_valid, tbl[k].x_wbv);
      chk($sformatf("v%0d_wbwe", k), wb_reg_write_en, tbl[k].x_wbwe);
      if (tbl[k].x_wbv) begin
        chk($sformatf("v%0d_wbd", k), wb_writedata, tbl[k].x_wbd);
        chk($sformatf("v%0d_wba", k), wb_reg_write_addr, tbl[k].i.rd);
      end
    end

    // load acked on its 4th request cycle, which is also the timeout cycle: ack wins
    drive(mk(1, 32'h300, 0, 5'd9, 1, 1, 0, 1)); tick(); drive(bubble);
    for (int c = 0; c < 3; c++) begin
      dmem_ack = 0; #1;
      chk("late_stall", mem_stall, 1); chk("late_addr", dmem_addr, 32'h300);
      tick(); chk("late_wbv", wb_valid, 0);
    end
    dmem_ack = 1; dmem_rdata = 32'h0BAD_F00D; #1;
    chk("late_stall_end", mem_stall, 0); chk("late_err", mem_err, 0);
    tick(); dmem_ack = 0;
    chk("late_wbv_done", wb_valid, 1); chk("late_wbwe", wb_reg_write_en, 1);
    chk("late_wbd", wb_writedata, 32'h0BAD_F00D);

    // timeout: no ack ever
    drive(mk(1, 32'h400, 0, 5'd10, 1, 1, 0, 1)); tick(); drive(bubble);
    for (int c = 0; c < 3; c++) begin
      #1; chk("to_req", dmem_req, 1); chk("to_stall", mem_stall, 1); chk("to_err", mem_err, 0);
      tick();
    end
    #1; chk("to_req4", dmem_req, 1); chk("to_stall4", mem_stall, 0); chk("to_err4", mem_err, 1);
    tick();
    chk("to_wbv", wb_valid, 1); chk("to_wbwe", wb_reg_write_en, 0);
    chk("to_req_after", dmem_req, 0); chk("to_err_after", mem_err, 0);

    // reset asserted mid-WAIT
    drive(mk(1, 32'h500, 0, 5'd11, 1, 1, 0, 1)); tick(); drive(bubble);
    #1; chk("rw_stall", mem_stall, 1);
    tick();
    #1; rst_n = 1'b0;
    #1;
    chk("rw_req", dmem_req, 0); chk("rw_stall0", mem_stall, 0); chk("rw_err", mem_err, 0);
    chk("rw_addr", dmem_addr, 0); chk("rw_wbv", wb_valid, 0); chk("rw_fwd", m_execute_out, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // randomized run against an instruction-level model
    mref = '0; waited = 0; ewv = 0; ewwe = 0; ewrd = 0; ewd = 0; prev_stall = 0; cur = '0;
    for (int c = 0; c < 600; c++) begin
      if (!prev_stall) begin
        int kind;
        kind = $urandom_range(2);
        cur.v = ($urandom_range(3) != 0);
        cur.a = $urandom() & 32'hFFFF_FFFC;
        if ($urandom_range(7) == 0) cur.a[1:0] = 2'($urandom_range(3, 1));
        cur.d = $urandom(); cur.rd = 5'($urandom_range(31));
        cur.re = (kind == 1); cur.wr = (kind == 2);
        cur.we = (kind != 2) && ($urandom_range(7) != 0);
        cur.sel = (kind == 1);
      end
      drive(cur);
      exp_req = mref.v && (mref.re || mref.wr) && (mref.a[1:0] == 2'b00);
      exp_mis = mref.v && (mref.re || mref.wr) && (mref.a[1:0] != 2'b00);
      dmem_ack = exp_req && ($urandom_range(3) == 0);
      dmem_rdata = $urandom();
      exp_to = exp_req && !dmem_ack && (waited == TO - 1);
      exp_stall = exp_req && !dmem_ack && !exp_to;
      #1;
      chk("rnd_req", dmem_req, exp_req); chk("rnd_stall", mem_stall, exp_stall);
      chk("rnd_err", mem_err, exp_mis || exp_to);
      chk("rnd_fwd_en", m_reg_write_en, mref.v && mref.we && !mref.re);
      if (exp_req) begin
        chk("rnd_addr", dmem_addr, mref.a); chk("rnd_we", dmem_we, mref.wr);
        if (mref.wr) chk("rnd_wdata", dmem_wdata, mref.d);
      end
      if (!exp_stall) begin
        ewv = mref.v; ewrd = mref.rd; ewwe = mref.v && mref.we && !(exp_mis || exp_to);
        ewd = mref.sel ? dmem_rdata : mref.a;
        mref = cur; waited = 0;
      end else begin
        ewv = 0; ewwe = 0; waited++;
      end
      prev_stall = exp_stall;
      tick();
      chk("rnd_wbv", wb_valid, ewv); chk("rnd_wbwe", wb_reg_write_en, ewwe);
      if (ewv) begin
        chk("rnd_wbd", wb_writedata, ewd); chk("rnd_wba", wb_reg_write_addr, ewrd);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
